// File: rtl/ipsmacge_rxframing_if.sv
// GMII receive pins and framed byte stream of the GE MAC receive path.
`default_nettype none

interface ipsmacge_rxframing_if #(
  parameter int DAT_DW = 8,
  parameter int DAT_EW = 4
);
  logic [DAT_DW-1:0] gmii_rxd;
  logic              gmii_rxdv;
  logic              gmii_rxer;
  logic [DAT_DW-1:0] rx_odat;
  logic              rx_osop;
  logic              rx_oeop;
  logic              rx_ovld;
  logic [DAT_EW-1:0] rx_oerr;

  modport master (
    output gmii_rxd, gmii_rxdv, gmii_rxer,
    input  rx_odat, rx_osop, rx_oeop, rx_ovld, rx_oerr
  );

  modport slave (
    input  gmii_rxd, gmii_rxdv, gmii_rxer,
    output rx_odat, rx_osop, rx_oeop, rx_ovld, rx_oerr
  );
endinterface

`default_nettype wire

// File: rtl/ipsmacge_rxframing.sv
// GMII receive framer: strips preamble/SFD and emits DA..FCS as a byte stream.
// Revision 1.0 - initial release.
`default_nettype none

module ipsmacge_rxframing #(
  parameter int DAT_DW   = 8,
  parameter int DAT_EW   = 4,
  parameter int LEN_W    = 14,
  parameter int MIN_LEN  = 64,
  parameter int PRE_FULL = 7
) (
  input  wire logic             rxclk,
  input  wire logic             rxrst_,
  input  wire logic [LEN_W-1:0] cfg_maxlen,
  ipsmacge_rxframing_if.slave   bus
);

  localparam int PRE_W = $clog2(PRE_FULL + 1);
  localparam logic [DAT_DW-1:0] PRE_BYTE = DAT_DW'(8'h55);
  localparam logic [DAT_DW-1:0] SFD_BYTE = DAT_DW'(8'hD5);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t            state, state_nx;

  logic [DAT_DW-1:0] in_d;
  logic              in_dv;
  logic              in_er;

  logic [DAT_DW-1:0] hold_d, hold_d_nx;
  logic              hold_er, hold_er_nx;
  logic              hold_sop, hold_sop_nx;

  logic [PRE_W-1:0]  pre_cnt, pre_cnt_nx;
  logic              short_pre, short_pre_nx;
  logic [LEN_W-1:0]  len_cnt, len_cnt_nx;
  logic              err_acc, err_acc_nx;

  logic [DAT_DW-1:0] out_dat, out_dat_nx;
  logic              out_sop, out_sop_nx;
  logic              out_eop, out_eop_nx;
  logic              out_vld, out_vld_nx;
  logic [DAT_EW-1:0] out_err, out_err_nx;

  logic              have_hold;
  logic [DAT_EW-1:0] frame_err;

  // len_cnt equals the index of the byte sitting in hold (0 means hold empty)
  assign have_hold = (len_cnt != '0);

  always_comb begin
    frame_err    = '0;
    frame_err[0] = err_acc;
    frame_err[1] = (len_cnt < LEN_W'(MIN_LEN));
    frame_err[3] = short_pre;
  end

  always_comb begin
    state_nx     = state;
    hold_d_nx    = hold_d;
    hold_er_nx   = hold_er;
    hold_sop_nx  = hold_sop;
    pre_cnt_nx   = pre_cnt;
    short_pre_nx = short_pre;
    len_cnt_nx   = len_cnt;
    err_acc_nx   = err_acc;
    out_dat_nx   = '0;
    out_sop_nx   = 1'b0;
    out_eop_nx   = 1'b0;
    out_vld_nx   = 1'b0;
    out_err_nx   = '0;

    case (state)
      IDLE: begin
        if (in_dv) begin
          if (in_d == PRE_BYTE) begin
            state_nx   = PRE;
            pre_cnt_nx = PRE_W'(1);
          end else begin
            state_nx = DROP;
          end
        end
      end

      PRE: begin
        if (!in_dv) begin
          state_nx = IDLE;
        end else if (in_er) begin
          state_nx = DROP;
        end else if (in_d == PRE_BYTE) begin
          if (pre_cnt < PRE_W'(PRE_FULL))
            pre_cnt_nx = pre_cnt + 1'b1;
        end else if (in_d == SFD_BYTE) begin
          state_nx     = DATA;
          short_pre_nx = (pre_cnt < PRE_W'(PRE_FULL));
          len_cnt_nx   = '0;
          err_acc_nx   = 1'b0;
        end else begin
          state_nx = DROP;
        end
      end

      DATA: begin
        if (!in_dv) begin
          state_nx = IDLE;
          if (have_hold) begin
            out_vld_nx = 1'b1;
            out_dat_nx = hold_d;
            out_sop_nx = hold_sop;
            out_eop_nx = 1'b1;
            out_err_nx = frame_err;
          end
        end else if (have_hold && (len_cnt == cfg_maxlen)) begin
          // frame already at the limit: close it on the held byte, drop the rest
          state_nx      = DROP;
          out_vld_nx    = 1'b1;
          out_dat_nx    = hold_d;
          out_sop_nx    = hold_sop;
          out_eop_nx    = 1'b1;
          out_err_nx    = frame_err;
          out_err_nx[2] = 1'b1;
        end else begin
          if (have_hold) begin
            out_vld_nx    = 1'b1;
            out_dat_nx    = hold_d;
            out_sop_nx    = hold_sop;
            out_err_nx[0] = hold_er;
          end
          hold_d_nx   = in_d;
          hold_er_nx  = in_er;
          hold_sop_nx = !have_hold;
          err_acc_nx  = err_acc | in_er;
          if (len_cnt != '1)
            len_cnt_nx = len_cnt + 1'b1;
        end
      end

      DROP: begin
        if (!in_dv)
          state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge rxclk or negedge rxrst_) begin
    if (!rxrst_) begin
      state     <= IDLE;
      in_d      <= '0;
      in_dv     <= 1'b0;
      in_er     <= 1'b0;
      hold_d    <= '0;
      hold_er   <= 1'b0;
      hold_sop  <= 1'b0;
      pre_cnt   <= '0;
      short_pre <= 1'b0;
      len_cnt   <= '0;
      err_acc   <= 1'b0;
      out_dat   <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_vld   <= 1'b0;
      out_err   <= '0;
    end else begin
      state     <= state_nx;
      in_d      <= bus.gmii_rxd;
      in_dv     <= bus.gmii_rxdv;
      in_er     <= bus.gmii_rxer;
      hold_d    <= hold_d_nx;
      hold_er   <= hold_er_nx;
      hold_sop  <= hold_sop_nx;
      pre_cnt   <= pre_cnt_nx;
      short_pre <= short_pre_nx;
      len_cnt   <= len_cnt_nx;
      err_acc   <= err_acc_nx;
      out_dat   <= out_dat_nx;
      out_sop   <= out_sop_nx;
      out_eop   <= out_eop_nx;
      out_vld   <= out_vld_nx;
      out_err   <= out_err_nx;
    end
  end

  assign bus.rx_odat = out_dat;
  assign bus.rx_osop = out_sop;
  assign bus.rx_oeop = out_eop;
  assign bus.rx_ovld = out_vld;
  assign bus.rx_oerr = out_err;

endmodule

`default_nettype wire

// File: doc/ipsmacge_rxframing.md
Name: ipsmacge_rxframing

Overview:
- GMII receive framer for the GE MAC receive path.
- Samples GMII rxd/rx_dv/rx_er, strips preamble and SFD, and emits the frame (DA through FCS) as a byte stream with sop/eop/vld/err.
- Output feeds the receive byte-to-word shifter directly.
- The last byte of every frame carries all frame-level error flags, because the shifter takes only the eop byte's error on the final word.

Parameters:
DAT_DW, 8, byte width of rxd/odat
DAT_EW, 4, error vector width
LEN_W, 14, byte length counter width
MIN_LEN, 64, runt threshold in bytes, FCS included
PRE_FULL, 7, number of 0x55 bytes for a full preamble

Ports:
rxclk  in  1  receive clock (125 MHz GMII)
rxrst_  in  1  reset: asynchronous, active-low
gmii_rxd  in  DAT_DW  GMII receive data
gmii_rxdv  in  1  GMII data valid
gmii_rxer  in  1  GMII receive error
cfg_maxlen  in  LEN_W  maximum frame bytes, FCS included; quasi-static
rx_odat  out  DAT_DW  frame byte
rx_osop  out  1  first byte after SFD
rx_oeop  out  1  last byte of frame
rx_ovld  out  1  byte valid
rx_oerr  out  DAT_EW  [0] rx_er, [1] runt, [2] oversize/truncated, [3] short preamble

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and all counters and flags are 0.
- Pipeline:
  - Stage 1 registers the GMII pins (in_d, in_dv, in_er).
  - Stage 2 is a one-byte hold register.
  - Stage 3 is the output register.
  - Every accepted byte appears on rx_o* exactly 3 cycles after it was on the pins. This holds for the eop byte too.
  - rx_ovld is contiguous within a frame and is 0 between frames.
- FSM states: IDLE, PRE, DATA, DROP. Transitions are evaluated on the stage-1 signals.
  - IDLE:
    - in_dv=1 and in_d=0x55: go to PRE, pre_cnt=1.
    - in_dv=1 and any other byte (including a bare 0xD5): go to DROP.
    - in_dv=0: stay in IDLE.
  - PRE:
    - in_dv=0: go to IDLE.
    - in_er=1: go to DROP.
    - 0x55: stay; pre_cnt saturates at PRE_FULL.
    - 0xD5: go to DATA. Latch short_pre = (pre_cnt < PRE_FULL). Clear len_cnt and err_acc.
    - Any other byte: go to DROP.
  - DATA:
    - Each in_dv=1 byte is loaded into hold. The previously held byte moves to the output with eop=0.
    - len_cnt increments and saturates at all-ones.
    - err_acc[0] |= in_er.
    - On in_dv=0: the held byte is output with eop=1, then go to IDLE.
  - DROP: discard all bytes; go to IDLE on in_dv=0.
- sop: set on the first byte after SFD. A 1-byte frame has sop=eop=1 on the same byte.
- Zero-length frame (SFD then dv low): no output and no error report.
- Non-eop bytes: rx_oerr = {3'b0, that byte's rx_er}.
- eop byte: rx_oerr is the cumulative frame result:
  - [0] = any rx_er in the frame.
  - [1] = final len_cnt < MIN_LEN.
  - [2] = truncated, as defined below.
  - [3] = short_pre.
- Oversize:
  - If the held byte is byte number cfg_maxlen and another in_dv=1 byte arrives, the held byte is output with eop=1 and [2]=1, and the FSM goes to DROP. The excess bytes are never output.
  - A frame of exactly cfg_maxlen bytes is normal, with [2]=0.
- Outside a frame, rx_er with dv=0 (carrier extension or false carrier) is ignored.
- Back-to-back frames with a 1-cycle dv gap: the eop of frame N and the first preamble byte of frame N+1 overlap in the pipeline without interaction.
- Asynchronous reset mid-frame: outputs clear immediately, and the partial frame gets no eop. After reset release the FSM is in IDLE. It enters DROP only if dv is still high with a non-0x55 byte.

Test Plan:
- 7x0x55, 0xD5, bytes 0x00..0x3F (64 bytes), dv low -> 64 vld bytes, 3-cycle latency, sop on 0x00, eop on 0x3F, err=0.
- 3x0x55, 0xD5, 64 bytes -> frame forwarded; eop err=4'b1000.
- Full preamble and 10 bytes, with rx_er on byte 5 -> byte 5 err=4'b0001; eop byte err=4'b0011 (rx_er + runt).
- cfg_maxlen=100, 150-byte frame -> exactly 100 vld bytes; byte 100 has eop and err=4'b0100; the remaining 50 are dropped. A separate 100-byte frame gives eop err=0.
- 0xD5 without preamble, or 0x55, 0x12 -> no output. 0x55, 0xD5, 1 byte -> single byte with sop=eop=1, err=4'b1010.
- Assert rxrst_ low on byte 30 of a frame while dv stays high for 10 more bytes, then a good frame follows -> no output after reset until the good frame, which is delivered intact.
